kmeans_assign_ctrl: RTL
=======================

Name: kmeans_assign_ctrl

Overview:
Sequencer for the shared 32-bit absolute-difference unit in the K-means datapath. Per input point it time-multiplexes the unit over every stored centroid and builds the Manhattan distance |px-cx|+|py-cy| for each one. It tracks the running minimum and returns the index of the nearest centroid plus its distance. It sits between the point stream and the centroid-update stage.

Parameters:
NUM_CENT, 4, number of centroids held in the internal table (2..16)
IDX_W, 2, width of centroid index (ceil(log2(NUM_CENT)))
W, 32, coordinate and distance width

Ports:
assign_clk  in  1  single clock, all logic on rising edge
assign_rst_n  in  1  synchronous active-low reset
cent_we  in  1  centroid table write strobe
cent_idx  in  IDX_W  centroid slot to write
cent_x  in  W  centroid X coordinate
cent_y  in  W  centroid Y coordinate
pt_valid  in  1  input point valid
pt_ready  out  1  controller can accept a point
pt_x  in  W  point X coordinate
pt_y  in  W  point Y coordinate
sub_a  out  W  operand A to the shared abs-diff unit
sub_b  out  W  operand B to the shared abs-diff unit
sub_res  in  W  |sub_a-sub_b| from the unit, combinational, same cycle
res_valid  out  1  result valid
res_ready  in  1  downstream accepts result
res_idx  out  IDX_W  index of nearest centroid
res_dist  out  W  Manhattan distance to nearest centroid
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (assign_rst_n=0 at a clock edge): state=IDLE. pt_ready=1, res_valid=0, res_idx=0, res_dist=0, sub_a=0, sub_b=0, busy=0. All centroid table entries are cleared to (0,0). Reset applies in any state and abandons any operation in progress; no partial result is emitted.
- Centroid table: the write takes effect on the clock edge when cent_we=1 and state=IDLE. When state is not IDLE, cent_we is ignored and the table is unchanged. cent_idx >= NUM_CENT is ignored.
- FSM states: IDLE, DX, DY, OUT.
- IDLE: pt_ready=1. A point is accepted when pt_valid & pt_ready. On acceptance:
  - latch pt_x and pt_y;
  - k=0;
  - best_dist = all ones;
  - best_idx = 0;
  - go to DX.
- DX: sub_a=px, sub_b=cx[k]. Register dx=sub_res, then go to DY.
- DY: sub_a=py, sub_b=cy[k]. Compute d = dx + sub_res at W+1 bits. If bit W is set, d saturates to 2^W-1.
  - If d < best_dist (strictly less), set best_dist=d and best_idx=k. On a tie, the lower index is kept.
  - If k == NUM_CENT-1, go to OUT. Otherwise k=k+1 and go to DX.
  - The update for the last centroid is visible in OUT.
- In IDLE and OUT, sub_a and sub_b are driven to 0.
- OUT: res_valid=1, res_idx=best_idx, res_dist=best_dist. These stay stable until res_valid & res_ready. On that handshake, go to IDLE with res_valid=0 on the next cycle. pt_ready=0 in OUT.
- Latency: point accepted at edge 0 gives res_valid=1 in the cycle after edge 2*NUM_CENT. With NUM_CENT=4, res_valid is visible after edge 8. Back-to-back throughput is one point per 2*NUM_CENT+2 cycles when res_ready=1.
- Arithmetic: sub_res is an unsigned magnitude. All comparisons are unsigned.
- Simultaneous events:
  - cent_we together with a point acceptance in IDLE: the write takes effect, and the point computation uses the updated value.
  - pt_valid outside IDLE: ignored, held off by pt_ready=0.

Test Plan:
- Nearest pick: load C0=(0,0), C1=(10,10), C2=(100,0), C3=(5,5); send point (6,7) -> distances 13, 7, 101, 3 -> res_idx=3, res_dist=3; res_valid rises 8 cycles after acceptance; sub_a/sub_b sequence is 6/0, 7/0, 6/10, 7/10, 6/100, 7/0, 6/5, 7/5.
- Tie: C0=(2,0), C1=(0,2), C2=C3=(50,50); point (0,0) -> res_idx=0, res_dist=2.
- Saturation: C0=(0,0), other centroids (0,0); point (0xFFFFFFFF, 0xFFFFFFFF) -> res_dist=0xFFFFFFFF, res_idx=0.
- Backpressure: hold res_ready=0 for 5 cycles in OUT -> res_idx and res_dist are stable, pt_ready=0, and a pt_valid pulse is ignored; raise res_ready -> IDLE next cycle, then the next point is accepted.
- Write while busy: cent_we with C0=(1,1) during DY of a run on the table from the first scenario -> table unchanged; re-run point (6,7) -> res_idx=3.
- Mid-operation reset: assert assign_rst_n=0 during DX of k=2 -> next cycle IDLE, res_valid=0, busy=0, and the table is all zeros; point (3,4) -> res_idx=0, res_dist=7.

Source files
------------

// File: rtl/kmeans_assign_ctrl.sv
// kmeans_assign_ctrl
//   Sequencer for a shared absolute-difference unit in the K-means datapath.
//   For each accepted point it walks the centroid table. Each centroid takes
//   two cycles: one for |px-cx| and one for |py-cy|. The controller builds a
//   saturating Manhattan distance per centroid, keeps the strictly smaller
//   running minimum, and reports the index and distance of the nearest
//   centroid.
//
// Ports
//   assign_clk, assign_rst_n   clock; synchronous active-low reset
//   cent_we/cent_idx/cent_x/cent_y   centroid table write (IDLE only)
//   pt_valid/pt_ready/pt_x/pt_y      input point stream
//   sub_a/sub_b/sub_res              shared abs-diff unit (combinational)
//   res_valid/res_ready/res_idx/res_dist   nearest-centroid result stream
//   busy                             high whenever not IDLE
//   state_dbg                        current FSM state (IDLE=0 DX=1 DY=2 OUT=3)
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high. A producer holds valid and its payload stable until that edge. Ready
// never depends on valid.
module kmeans_assign_ctrl #(
  parameter int NUM_CENT = 4,
  parameter int IDX_W    = 2,
  parameter int W        = 32
) (
  input  logic             assign_clk,
  input  logic             assign_rst_n,
  input  logic             cent_we,
  input  logic [IDX_W-1:0] cent_idx,
  input  logic [W-1:0]     cent_x,
  input  logic [W-1:0]     cent_y,
  input  logic             pt_valid,
  output logic             pt_ready,
  input  logic [W-1:0]     pt_x,
  input  logic [W-1:0]     pt_y,
  output logic [W-1:0]     sub_a,
  output logic [W-1:0]     sub_b,
  input  logic [W-1:0]     sub_res,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [IDX_W-1:0] res_idx,
  output logic [W-1:0]     res_dist,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, DX = 2'd1, DY = 2'd2, OUT = 2'd3} state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     px, py, dx;
  logic [W-1:0]     best_dist;
  logic [IDX_W-1:0] best_idx;
  logic [IDX_W-1:0] k;
  logic [W-1:0]     cx [NUM_CENT];
  logic [W-1:0]     cy [NUM_CENT];

  logic [W:0]       d_sum;
  logic [W-1:0]     d_sat;
  logic             last;

  // Sum carries one extra bit so an overflow clamps to all ones instead of
  // wrapping to a small, wrongly "near" distance.
  assign d_sum = {1'b0, dx} + {1'b0, sub_res};
  assign d_sat = d_sum[W] ? '1 : d_sum[W-1:0];
  assign last  = (k == IDX_W'(NUM_CENT - 1));

  assign state_dbg = state;

  always_ff @(posedge assign_clk) begin
    if (!assign_rst_n) begin
      state     <= IDLE;
      px        <= '0;
      py        <= '0;
      dx        <= '0;
      k         <= '0;
      best_dist <= '0;
      best_idx  <= '0;
      for (int i = 0; i < NUM_CENT; i++) begin
        cx[i] <= '0;
        cy[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      // Table only changes while idle, so a run in flight always sees one
      // consistent set of centroids.
      if (state == IDLE && cent_we && int'(cent_idx) < NUM_CENT) begin
        cx[cent_idx] <= cent_x;
        cy[cent_idx] <= cent_y;
      end
      case (state)
        IDLE: begin
          if (pt_valid) begin
            px        <= pt_x;
            py        <= pt_y;
            k         <= '0;
            best_dist <= '1;
            best_idx  <= '0;
          end
        end
        DX: dx <= sub_res;
        DY: begin
          // Strict less-than keeps the lower index on ties.
          if (d_sat < best_dist) begin
            best_dist <= d_sat;
            best_idx  <= k;
          end
          if (!last) k <= k + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    pt_ready  = 1'b0;
    res_valid = 1'b0;
    res_idx   = '0;
    res_dist  = '0;
    sub_a     = '0;
    sub_b     = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        pt_ready = 1'b1;
        if (pt_valid) state_nxt = DX;
      end
      DX: begin
        sub_a     = px;
        sub_b     = cx[k];
        state_nxt = DY;
      end
      DY: begin
        sub_a     = py;
        sub_b     = cy[k];
        state_nxt = last ? OUT : DX;
      end
      OUT: begin
        res_valid = 1'b1;
        res_idx   = best_idx;
        res_dist  = best_dist;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
